cru_bit_latch: RTL and testbench

CRU output-bit latch that consumes the serial CRU write cycles produced by the CRU write cycle generator (`cruclk`, `cruout`, `address_bus`). It decodes a 16-bit CRU window at a fixed base address and captures the `cruout` bit into an addressable 16-bit output register. It rejects `cruclk` low pulses shorter than a programmable minimum. It sits directly downstream of the write generator and drives peripheral control lines (LEDs, enables, mode bits).

---
 rtl/cru_bit_latch.sv | 135 +++++++++++++
 tb/tb_cru_bit_latch.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cru_bit_latch.sv
`default_nettype none
// ============================================================================
// Module   : cru_bit_latch
// Purpose  : CRU output-bit latch with low-pulse width filtering.
// Revision : 1.0 - initial release
// ============================================================================
module cru_bit_latch #(
    parameter logic [15:0] BASE_ADDR   = 16'h1300,
    parameter int unsigned MIN_LOW     = 1,
    parameter logic [15:0] RESET_VALUE = 16'h0000
) (
    input  logic        phi2,
    input  logic        reset_n,
    input  logic        cruclk,
    input  logic        cruout,
    input  logic [15:0] address_bus,
    output logic [15:0] bits,
    output logic        bit_strobe,
    output logic [3:0]  strobe_index,
    output logic        busy,
    output logic [7:0]  glitch_count
);

    localparam logic [1:0] c_idle      = 2'd0;
    localparam logic [1:0] c_low_wait  = 2'd1;
    localparam logic [1:0] c_commit    = 2'd2;
    localparam logic [1:0] c_wait_high = 2'd3;
    localparam logic [3:0] c_min_low   = 4'(MIN_LOW);

    logic        r_clk_q;
    logic        r_clk_qq;
    logic        r_dat_q;
    logic [15:0] r_adr_q;
    logic        r_armed;

    logic [1:0]  r_state;
    logic [15:0] r_hold_adr;
    logic        r_hold_dat;
    logic [3:0]  r_low_cnt;
    logic [15:0] r_bits;
    logic        r_strobe;
    logic [3:0]  r_strobe_index;
    logic [7:0]  r_glitch_count;

    logic        w_fall;
    logic        w_hit;
    logic [3:0]  w_idx;
    logic [3:0]  w_low_cnt_inc;
    logic        w_unused_ok;

    // r_armed blocks a false edge when cruclk is still low as reset releases:
    // an edge is only valid once cruclk has been seen high after reset.
    always_ff @(posedge phi2) begin
        if (!reset_n) begin
            r_clk_q  <= 1'b1;
            r_clk_qq <= 1'b1;
            r_dat_q  <= 1'b0;
            r_adr_q  <= 16'h0000;
            r_armed  <= 1'b0;
        end else begin
            r_clk_q  <= cruclk;
            r_clk_qq <= r_clk_q;
            r_dat_q  <= cruout;
            r_adr_q  <= address_bus;
            r_armed  <= r_armed | cruclk;
        end
    end

    assign w_fall        = r_clk_qq & ~r_clk_q & r_armed;
    assign w_hit         = (r_hold_adr[15:5] == BASE_ADDR[15:5]);
    assign w_idx         = r_hold_adr[4:1];
    assign w_low_cnt_inc = r_low_cnt + 4'd1;
    assign w_unused_ok   = &{1'b0, r_hold_adr[0]};

    always_ff @(posedge phi2) begin
        if (!reset_n) begin
            r_state        <= c_idle;
            r_hold_adr     <= 16'h0000;
            r_hold_dat     <= 1'b0;
            r_low_cnt      <= 4'd0;
            r_bits         <= RESET_VALUE;
            r_strobe       <= 1'b0;
            r_strobe_index <= 4'd0;
            r_glitch_count <= 8'h00;
        end else begin
            r_strobe <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (w_fall) begin
                        r_hold_adr <= r_adr_q;
                        r_hold_dat <= r_dat_q;
                        r_low_cnt  <= 4'd1;
                        r_state    <= (c_min_low == 4'd1) ? c_commit : c_low_wait;
                    end
                end
                c_low_wait: begin
                    if (r_clk_q) begin
                        if (r_glitch_count != 8'hFF) begin
                            r_glitch_count <= r_glitch_count + 8'd1;
                        end
                        r_state <= c_idle;
                    end else begin
                        r_low_cnt <= w_low_cnt_inc;
                        if (w_low_cnt_inc == c_min_low) begin
                            r_state <= c_commit;
                        end
                    end
                end
                c_commit: begin
                    if (w_hit) begin
                        r_bits[w_idx]  <= r_hold_dat;
                        r_strobe_index <= w_idx;
                        r_strobe       <= 1'b1;
                    end
                    r_state <= c_wait_high;
                end
                c_wait_high: begin
                    // One write per low pulse regardless of its length.
                    if (r_clk_q) begin
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign bits         = r_bits;
    assign bit_strobe   = r_strobe;
    assign strobe_index = r_strobe_index;
    assign glitch_count = r_glitch_count;
    assign busy         = (r_state != c_idle);

endmodule
`default_nettype wire

// File: tb/tb_cru_bit_latch.sv
`default_nettype none
// ============================================================================
// Module   : tb_cru_bit_latch
// Purpose  : Self-checking bench for cru_bit_latch (MIN_LOW = 1, 3, 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cru_bit_latch;

    typedef struct {
        int          inst;
        logic [15:0] bits;
        logic [3:0]  idx;
    } exp_t;

    typedef struct {
        int          inst;
        logic [15:0] addr;
        logic        dat;
        int          low_len;
        logic        wr;
        logic [15:0] exp_bits;
        logic [7:0]  exp_glitch;
    } vec_t;

    logic             phi2 = 1'b0;
    logic             reset_n = 1'b0;
    logic [2:0]       cruclk_v = 3'b111;
    logic [2:0]       cruout_v = 3'b000;
    logic [2:0][15:0] addr_v = '0;
    logic [2:0][15:0] bits_v;
    logic [2:0]       strobe_v;
    logic [2:0][3:0]  idx_v;
    logic [2:0]       busy_v;
    logic [2:0][7:0]  glitch_v;

    int   errors = 0;
    int   checks = 0;
    int   strobe_cnt [3] = '{0, 0, 0};
    int   ml [3] = '{1, 3, 4};
    exp_t sb_q [$];
    exp_t e;
    vec_t vecs [14];

    always #5 phi2 = ~phi2;

    cru_bit_latch #(.BASE_ADDR(16'h1300), .MIN_LOW(1), .RESET_VALUE(16'hA5A5)) u_dut0 (
        .phi2(phi2), .reset_n(reset_n), .cruclk(cruclk_v[0]), .cruout(cruout_v[0]),
        .address_bus(addr_v[0]), .bits(bits_v[0]), .bit_strobe(strobe_v[0]),
        .strobe_index(idx_v[0]), .busy(busy_v[0]), .glitch_count(glitch_v[0]));

    cru_bit_latch #(.BASE_ADDR(16'h1300), .MIN_LOW(3), .RESET_VALUE(16'h0000)) u_dut1 (
        .phi2(phi2), .reset_n(reset_n), .cruclk(cruclk_v[1]), .cruout(cruout_v[1]),
        .address_bus(addr_v[1]), .bits(bits_v[1]), .bit_strobe(strobe_v[1]),
        .strobe_index(idx_v[1]), .busy(busy_v[1]), .glitch_count(glitch_v[1]));

    cru_bit_latch #(.BASE_ADDR(16'h1300), .MIN_LOW(4), .RESET_VALUE(16'h0000)) u_dut2 (
        .phi2(phi2), .reset_n(reset_n), .cruclk(cruclk_v[2]), .cruout(cruout_v[2]),
        .address_bus(addr_v[2]), .bits(bits_v[2]), .bit_strobe(strobe_v[2]),
        .strobe_index(idx_v[2]), .busy(busy_v[2]), .glitch_count(glitch_v[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse(input int k, input logic [15:0] a, input logic d, input int len);
        @(posedge phi2); #1;
        addr_v[k]   = a;
        cruout_v[k] = d;
        cruclk_v[k] = 1'b0;
        repeat (len) @(posedge phi2);
        #1 cruclk_v[k] = 1'b1;
        repeat (ml[k] + 4) @(posedge phi2);
    endtask

    // Scoreboard: every strobe must match the oldest pending expected write.
    always @(negedge phi2) begin
        for (int k = 0; k < 3; k++) begin
            if (strobe_v[k]) begin
                strobe_cnt[k]++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe inst%0d: bits=%h idx=%0d, no write expected",
                             k, bits_v[k], idx_v[k]);
                end else begin
                    e = sb_q.pop_front();
                    if (e.inst != k || e.bits !== bits_v[k] || e.idx !== idx_v[k]) begin
                        errors++;
                        $display("FAIL strobe inst%0d: bits=%h idx=%0d, expected inst%0d bits=%h idx=%0d",
                                 k, bits_v[k], idx_v[k], e.inst, e.bits, e.idx);
                    end
                end
            end
        end
    end

    initial begin
        int c0;

        vecs[0]  = '{0, 16'h130A, 1'b0, 1, 1'b1, 16'hA585, 8'd0};
        vecs[1]  = '{0, 16'h1300, 1'b0, 1, 1'b1, 16'hA584, 8'd0};
        vecs[2]  = '{0, 16'h1301, 1'b1, 1, 1'b1, 16'hA585, 8'd0};
        vecs[3]  = '{0, 16'h1320, 1'b1, 1, 1'b0, 16'hA585, 8'd0};
        vecs[4]  = '{0, 16'h131E, 1'b0, 2, 1'b1, 16'h2585, 8'd0};
        vecs[5]  = '{0, 16'h131C, 1'b1, 1, 1'b1, 16'h6585, 8'd0};
        vecs[6]  = '{1, 16'h1300, 1'b1, 2, 1'b0, 16'h0000, 8'd1};
        vecs[7]  = '{1, 16'h1300, 1'b1, 3, 1'b1, 16'h0001, 8'd1};
        vecs[8]  = '{1, 16'h1302, 1'b1, 1, 1'b0, 16'h0001, 8'd2};
        vecs[9]  = '{1, 16'h1302, 1'b1, 5, 1'b1, 16'h0003, 8'd2};
        vecs[10] = '{1, 16'h1320, 1'b1, 3, 1'b0, 16'h0003, 8'd2};
        vecs[11] = '{1, 16'h1320, 1'b1, 1, 1'b0, 16'h0003, 8'd3};
        vecs[12] = '{2, 16'h1306, 1'b1, 4, 1'b1, 16'h0008, 8'd0};
        vecs[13] = '{2, 16'h1306, 1'b0, 3, 1'b0, 16'h0008, 8'd1};

        // Reset
        repeat (2) @(posedge phi2);
        #1 reset_n = 1'b1;
        @(negedge phi2);
        chk("reset_bits0",   32'(bits_v[0]),   32'hA5A5);
        chk("reset_glitch0", 32'(glitch_v[0]), 32'h0);
        chk("reset_busy0",   32'(busy_v[0]),   32'h0);
        chk("reset_strobe0", 32'(strobe_v[0]), 32'h0);
        chk("reset_idx0",    32'(idx_v[0]),    32'h0);
        chk("reset_bits1",   32'(bits_v[1]),   32'h0);

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) sb_q.push_back('{vecs[i].inst, vecs[i].exp_bits, vecs[i].addr[4:1]});
            pulse(vecs[i].inst, vecs[i].addr, vecs[i].dat, vecs[i].low_len);
            chk($sformatf("vec%0d_bits", i),   32'(bits_v[vecs[i].inst]),   32'(vecs[i].exp_bits));
            chk($sformatf("vec%0d_glitch", i), 32'(glitch_v[vecs[i].inst]), 32'(vecs[i].exp_glitch));
            chk($sformatf("vec%0d_pending", i), 32'(sb_q.size()), 32'h0);
        end

        // Exact latency with MIN_LOW=1, idx 5
        sb_q.push_back('{0, 16'h65A5, 4'd5});
        @(posedge phi2); #1;
        addr_v[0] = 16'h130A; cruout_v[0] = 1'b1; cruclk_v[0] = 1'b0;
        @(posedge phi2); #1 cruclk_v[0] = 1'b1;
        @(negedge phi2);
        chk("lat_n_bits",   32'(bits_v[0]),   32'h6585);
        chk("lat_n_strobe", 32'(strobe_v[0]), 32'h0);
        @(negedge phi2);
        chk("lat_n1_busy",  32'(busy_v[0]),   32'h1);
        chk("lat_n1_bits",  32'(bits_v[0]),   32'h6585);
        @(negedge phi2);
        chk("lat_n2_bits",   32'(bits_v[0]),   32'h65A5);
        chk("lat_n2_strobe", 32'(strobe_v[0]), 32'h1);
        chk("lat_n2_idx",    32'(idx_v[0]),    32'h5);
        @(negedge phi2);
        chk("lat_n3_strobe", 32'(strobe_v[0]), 32'h0);
        chk("lat_n3_busy",   32'(busy_v[0]),   32'h0);
        repeat (3) @(posedge phi2);
        chk("lat_pending", 32'(sb_q.size()), 32'h0);

        // Miss: busy pulses, no strobe
        c0 = strobe_cnt[0];
        @(posedge phi2); #1;
        addr_v[0] = 16'h1320; cruout_v[0] = 1'b1; cruclk_v[0] = 1'b0;
        @(posedge phi2); #1 cruclk_v[0] = 1'b1;
        @(negedge phi2);
        @(negedge phi2);
        chk("miss_busy", 32'(busy_v[0]), 32'h1);
        repeat (4) @(posedge phi2);
        chk("miss_strobes", 32'(strobe_cnt[0] - c0), 32'h0);
        chk("miss_bits",    32'(bits_v[0]),           32'h65A5);

        // Long pulse with data/address change while low
        c0 = strobe_cnt[0];
        sb_q.push_back('{0, 16'hE5A5, 4'd15});
        @(posedge phi2); #1;
        addr_v[0] = 16'h131E; cruout_v[0] = 1'b1; cruclk_v[0] = 1'b0;
        @(posedge phi2); #1;
        addr_v[0] = 16'h1306; cruout_v[0] = 1'b0;
        repeat (9) @(posedge phi2);
        #1 cruclk_v[0] = 1'b1;
        repeat (5) @(posedge phi2);
        chk("long_strobes", 32'(strobe_cnt[0] - c0), 32'h1);
        chk("long_bits",    32'(bits_v[0]),           32'hE5A5);
        chk("long_pending", 32'(sb_q.size()),         32'h0);

        // Glitch counter saturation
        for (int i = 0; i < 260; i++) pulse(1, 16'h1300, 1'b1, 1);
        chk("glitch_sat",      32'(glitch_v[1]), 32'hFF);
        chk("glitch_sat_bits", 32'(bits_v[1]),   32'h0003);

        // Reset during LOW_WAIT with cruclk held low across release
        c0 = strobe_cnt[2];
        @(posedge phi2); #1;
        addr_v[2] = 16'h1300; cruout_v[2] = 1'b1; cruclk_v[2] = 1'b0;
        repeat (2) @(posedge phi2);
        @(negedge phi2);
        chk("rst_mid_busy", 32'(busy_v[2]), 32'h1);
        reset_n = 1'b0;
        @(posedge phi2); #1 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge phi2);
            chk($sformatf("rst_hold_busy%0d", i), 32'(busy_v[2]), 32'h0);
        end
        chk("rst_hold_strobes", 32'(strobe_cnt[2] - c0), 32'h0);
        chk("rst_hold_bits",    32'(bits_v[2]),           32'h0);
        chk("rst_glitch1",      32'(glitch_v[1]),         32'h0);
        chk("rst_bits0",        32'(bits_v[0]),           32'hA5A5);
        @(posedge phi2); #1 cruclk_v[2] = 1'b1;
        repeat (2) @(posedge phi2);
        sb_q.push_back('{2, 16'h0001, 4'd0});
        pulse(2, 16'h1300, 1'b1, 4);
        chk("rst_after_bits",    32'(bits_v[2]),   32'h0001);
        chk("rst_after_pending", 32'(sb_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
